// File: rtl/score_panel_if.sv
// ---------------------------------------------------------------------------
// score_panel_if
//   Bundles the frame statistics, pixel position, glyph ROM path and panel
//   pixel output of score_panel. Port names are unchanged from the flat
//   port list so existing wiring maps one-to-one.
//
//   frame_start_i  one-cycle pulse at the start of each frame
//   tank_left_i    enemy tanks remaining
//   level_i        current level
//   lives_i        lives per player, player p in [4p+3:4p]
//   hpos_i/vpos_i  current pixel position
//   glyph_addr_o   {char[5:0], glyph_row[3:0]} to the synchronous ASCII ROM
//   glyph_data_i   ROM row bits, valid one cycle after glyph_addr_o
//   red_o/green_o/blue_o  panel pixel colour
//   enable_o       panel pixel is opaque
//
//   slave  : the panel side (score_panel)
//   master : the game/video side driving statistics and consuming pixels
// ---------------------------------------------------------------------------
interface score_panel_if #(
   parameter int COLOR_BITS  = 24,
   parameter int NUM_PLAYERS = 2
);
   logic                       frame_start_i;
   logic [5:0]                 tank_left_i;
   logic [3:0]                 level_i;
   logic [4*NUM_PLAYERS-1:0]   lives_i;
   logic [9:0]                 hpos_i;
   logic [9:0]                 vpos_i;
   logic [9:0]                 glyph_addr_o;
   logic [7:0]                 glyph_data_i;
   logic [COLOR_BITS/3-1:0]    red_o;
   logic [COLOR_BITS/3-1:0]    green_o;
   logic [COLOR_BITS/3-1:0]    blue_o;
   logic                       enable_o;

   modport slave (
      input  frame_start_i, tank_left_i, level_i, lives_i,
      input  hpos_i, vpos_i, glyph_data_i,
      output glyph_addr_o, red_o, green_o, blue_o, enable_o
   );

   modport master (
      output frame_start_i, tank_left_i, level_i, lives_i,
      output hpos_i, vpos_i, glyph_data_i,
      input  glyph_addr_o, red_o, green_o, blue_o, enable_o
   );
endinterface

// File: rtl/score_panel.sv
// ---------------------------------------------------------------------------
// score_panel
//   Right-hand HUD panel: enemy-tank reserve columns, one lives row per
//   player and the "LEVEL n" caption. Statistics are shadowed on each
//   frame_start_i so the panel is stable within a frame. A level change
//   switches the caption to banner colours for BANNER_FRAMES frames.
//   Pixel output has a fixed 2-clock latency from hpos_i/vpos_i.
//
//   Ports:
//     clk_i   pixel clock
//     rst_ni  asynchronous active-low reset
//     bus     score_panel_if.slave (statistics, position, glyph ROM, pixel)
//
//   Build option:
//     SCORE_PANEL_BLINK_EN  when defined, a player's lives row blinks for
//                           BLINK_FRAMES frames after losing a life; when
//                           undefined, lives rows are always drawn.
// ---------------------------------------------------------------------------
module score_panel #(
   parameter int COLOR_BITS    = 24,
   parameter int NUM_PLAYERS   = 2,
   parameter int TANK_ROWS     = 16,
   parameter int TANK_X0       = 480,
   parameter int TANK_Y0       = 32,
   parameter int LIVES_X0      = 464,
   parameter int LIVES_Y0      = 384,
   parameter int LIVES_DY      = 32,
   parameter int LEVEL_X0      = 464,
   parameter int LEVEL_Y0      = 320,
   parameter int BLINK_FRAMES  = 64,
   parameter int BANNER_FRAMES = 120
) (
   input logic           clk_i,
   input logic           rst_ni,
   score_panel_if.slave  bus
);

   localparam int CW  = COLOR_BITS / 3;
   localparam int BNW = $clog2(BANNER_FRAMES + 1);

   localparam logic [9:0] TX0    = 10'(TANK_X0);
   localparam logic [9:0] TX1    = 10'(TANK_X0 + 16);
   localparam logic [9:0] TX_END = 10'(TANK_X0 + 32);
   localparam logic [9:0] TY0    = 10'(TANK_Y0);
   localparam logic [9:0] TY_END = 10'(TANK_Y0 + 16 * TANK_ROWS);
   localparam logic [6:0] T_ROWS = 7'(TANK_ROWS);
   localparam logic [6:0] T_MAX  = 7'(2 * TANK_ROWS);

   localparam logic [9:0] LX0    = 10'(LIVES_X0);
   localparam logic [9:0] LX_END = 10'(LIVES_X0 + 16 * 8);

   localparam logic [9:0] CX0    = 10'(LEVEL_X0);
   localparam logic [9:0] CX_END = 10'(LEVEL_X0 + 16 * 7);
   localparam logic [9:0] CY0    = 10'(LEVEL_Y0);
   localparam logic [9:0] CY_END = 10'(LEVEL_Y0 + 32);

   localparam logic [23:0] TANK_RGB   = 24'h808080;
   localparam logic [23:0] LIVES_RGB  = 24'hE0A000;
   localparam logic [23:0] IDLE_BG    = 24'hE0E0E0;
   localparam logic [23:0] BANNER_FG  = 24'hFFD000;

   typedef enum logic {
      IDLE,
      BANNER
   } state_t;

   // Icon cell: opaque where both local coordinates lie in 2..13.
   function automatic logic icon_px(input logic [3:0] lx, input logic [3:0] ly);
      return (lx >= 4'd2) && (lx <= 4'd13) && (ly >= 4'd2) && (ly <= 4'd13);
   endfunction

   // Keeps the top CW bits of an 8-bit channel, zero-padding when CW > 8.
   function automatic logic [CW-1:0] scale8(input logic [7:0] c);
      logic [CW+7:0] wide;
      wide = {c, {CW{1'b0}}};
      return wide[CW+7 -: CW];
   endfunction

   // ------------------------------------------------------------------
   // Shadow registers, sampled once per frame
   // ------------------------------------------------------------------
   logic                     primed;
   logic [5:0]               sh_tanks;
   logic [3:0]               sh_level;
   logic [4*NUM_PLAYERS-1:0] sh_lives;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         primed   <= 1'b0;
         sh_tanks <= '0;
         sh_level <= '0;
         sh_lives <= '0;
      end else if (bus.frame_start_i) begin
         primed   <= 1'b1;
         sh_tanks <= bus.tank_left_i;
         sh_level <= bus.level_i;
         sh_lives <= bus.lives_i;
      end
   end

   // ------------------------------------------------------------------
   // Life-loss blink
   // ------------------------------------------------------------------
   logic [NUM_PLAYERS-1:0] lives_vis;

`ifdef SCORE_PANEL_BLINK_EN
   localparam int BW = $clog2(BLINK_FRAMES + 1);

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_blink
      logic [BW-1:0] cnt_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            cnt_q <= '0;
         end else if (bus.frame_start_i) begin
            if (primed && (bus.lives_i[4*p +: 4] < sh_lives[4*p +: 4]))
               cnt_q <= BW'(BLINK_FRAMES);
            else if (cnt_q != '0)
               cnt_q <= cnt_q - BW'(1);
         end
      end

      assign lives_vis[p] = !((cnt_q != '0) && cnt_q[3]);
   end
`else
   assign lives_vis = '1;
`endif

   // ------------------------------------------------------------------
   // Level banner FSM
   // ------------------------------------------------------------------
   state_t         state_q, state_d;
   logic [BNW-1:0] banner_cnt_q, banner_cnt_d;
   logic           level_change;

   assign level_change = bus.frame_start_i && primed && (bus.level_i != sh_level);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         banner_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         banner_cnt_q <= banner_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      banner_cnt_d = banner_cnt_q;
      case (state_q)
         IDLE: begin
            if (level_change) begin
               state_d      = BANNER;
               banner_cnt_d = BNW'(BANNER_FRAMES);
            end
         end
         BANNER: begin
            if (level_change) begin
               banner_cnt_d = BNW'(BANNER_FRAMES);
            end else if (bus.frame_start_i) begin
               banner_cnt_d = banner_cnt_q - BNW'(1);
               if (banner_cnt_q == BNW'(1))
                  state_d = IDLE;
            end
         end
         default: begin
            state_d      = IDLE;
            banner_cnt_d = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Cycle N: region decode from hpos/vpos
   // ------------------------------------------------------------------
   // Tank columns
   logic [9:0] tdx, tdy;
   logic [6:0] t_sat, col0_cnt, col1_cnt, icon_idx;
   logic       in_ty, in_col0, in_col1, tank_hit;

   always_comb begin
      tdx      = bus.hpos_i - TX0;
      tdy      = bus.vpos_i - TY0;
      t_sat    = ({1'b0, sh_tanks} > T_MAX) ? T_MAX : {1'b0, sh_tanks};
      col0_cnt = (t_sat > T_ROWS) ? T_ROWS : t_sat;
      col1_cnt = (t_sat > T_ROWS) ? (t_sat - T_ROWS) : '0;
      icon_idx = {1'b0, tdy[9:4]};
      in_ty    = (bus.vpos_i >= TY0) && (bus.vpos_i < TY_END);
      in_col0  = (bus.hpos_i >= TX0) && (bus.hpos_i < TX1);
      in_col1  = (bus.hpos_i >= TX1) && (bus.hpos_i < TX_END);
      // Column 1 starts exactly 16 px right, so tdx[3:0] is the local x for both.
      tank_hit = in_ty && icon_px(tdx[3:0], tdy[3:0]) &&
                 ((in_col0 && (icon_idx < col0_cnt)) ||
                  (in_col1 && (icon_idx < col1_cnt)));
   end

   // Lives rows
   logic [9:0]             ldx;
   logic                   in_lx;
   logic [NUM_PLAYERS-1:0] lives_row_hit;
   logic                   lives_hit;

   assign ldx   = bus.hpos_i - LX0;
   assign in_lx = (bus.hpos_i >= LX0) && (bus.hpos_i < LX_END);

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lives
      localparam logic [9:0] RY0 = 10'(LIVES_Y0 + p * LIVES_DY);
      localparam logic [9:0] RY1 = 10'(LIVES_Y0 + p * LIVES_DY + 16);
      logic [9:0] ldy;
      logic [3:0] cnt;

      assign ldy = bus.vpos_i - RY0;
      assign cnt = (sh_lives[4*p +: 4] > 4'd8) ? 4'd8 : sh_lives[4*p +: 4];
      assign lives_row_hit[p] = lives_vis[p] && in_lx &&
                                (bus.vpos_i >= RY0) && (bus.vpos_i < RY1) &&
                                ({1'b0, ldx[6:4]} < cnt) &&
                                icon_px(ldx[3:0], ldy[3:0]);
   end

   assign lives_hit = |lives_row_hit;

   // Caption "LEVEL n"
   logic [9:0] cdx, cdy;
   logic       in_cap;
   logic [3:0] lvl_sat;
   logic [5:0] char_code;

   always_comb begin
      cdx     = bus.hpos_i - CX0;
      cdy     = bus.vpos_i - CY0;
      in_cap  = (bus.hpos_i >= CX0) && (bus.hpos_i < CX_END) &&
                (bus.vpos_i >= CY0) && (bus.vpos_i < CY_END);
      lvl_sat = (sh_level > 4'd9) ? 4'd9 : sh_level;
      case (cdx[6:4])
         3'd0:    char_code = 6'd22;
         3'd1:    char_code = 6'd15;
         3'd2:    char_code = 6'd32;
         3'd3:    char_code = 6'd15;
         3'd4:    char_code = 6'd22;
         3'd5:    char_code = 6'd37;
         default: char_code = 6'd1 + {2'b00, lvl_sat};
      endcase
      bus.glyph_addr_o = in_cap ? {char_code, cdy[4:1]} : '0;
   end

   // ------------------------------------------------------------------
   // Stage 1: aligned with glyph_data_i
   // ------------------------------------------------------------------
   logic        s1_cap, s1_obj, s1_banner;
   logic [2:0]  s1_bit_sel;
   logic [23:0] s1_obj_rgb;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_cap     <= 1'b0;
         s1_obj     <= 1'b0;
         s1_banner  <= 1'b0;
         s1_bit_sel <= '0;
         s1_obj_rgb <= '0;
      end else begin
         // Nothing is drawn until the first frame after reset has latched stats.
         s1_cap     <= primed && in_cap;
         s1_obj     <= primed && (lives_hit || tank_hit);
         s1_banner  <= (state_q == BANNER);
         s1_bit_sel <= ~cdx[3:1];
         s1_obj_rgb <= lives_hit ? LIVES_RGB : TANK_RGB;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: final colour select and output registers
   // ------------------------------------------------------------------
   logic        glyph_bit;
   logic [23:0] pix;
   logic        pix_en;

   always_comb begin
      glyph_bit = bus.glyph_data_i[s1_bit_sel];
      pix       = '0;
      pix_en    = 1'b0;
      if (s1_cap) begin
         pix_en = 1'b1;
         if (s1_banner)
            pix = glyph_bit ? BANNER_FG : 24'h000000;
         else
            pix = glyph_bit ? 24'h000000 : IDLE_BG;
      end else if (s1_obj) begin
         pix_en = 1'b1;
         pix    = s1_obj_rgb;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bus.red_o    <= '0;
         bus.green_o  <= '0;
         bus.blue_o   <= '0;
         bus.enable_o <= 1'b0;
      end else begin
         bus.red_o    <= scale8(pix[23:16]);
         bus.green_o  <= scale8(pix[15:8]);
         bus.blue_o   <= scale8(pix[7:0]);
         bus.enable_o <= pix_en;
      end
   end

endmodule

// File: tb/tb_score_panel.sv
module tb_score_panel;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   score_panel_if #(.COLOR_BITS(24), .NUM_PLAYERS(2)) pif ();

   score_panel #(.COLOR_BITS(24), .NUM_PLAYERS(2)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (pif)
   );

`ifdef SCORE_PANEL_BLINK_EN
   localparam bit BLINK_ON = 1'b1;
`else
   localparam bit BLINK_ON = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [5:0]  tanks;
      logic [7:0]  lives;
      int          x;
      int          y;
      logic [7:0]  glyph;
      logic [9:0]  addr;
      logic        en;
      logic [23:0] rgb;
   } vec_t;

   vec_t vt [20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic frame_pulse();
      @(negedge clk);
      pif.frame_start_i = 1'b1;
      @(negedge clk);
      pif.frame_start_i = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame_pulse();
   endtask

   // Presents a position for one cycle only, then parks on a transparent
   // pixel, so the sampled result must appear exactly two clocks later.
   task automatic probe(input string name, input int x, input int y, input logic [7:0] g,
                        input logic [9:0] exp_addr, input logic exp_en, input logic [23:0] exp_rgb);
      @(negedge clk);
      pif.hpos_i       = 10'(x);
      pif.vpos_i       = 10'(y);
      pif.glyph_data_i = g;
      #1;
      check({name, ".addr"}, 32'(pif.glyph_addr_o), 32'(exp_addr));
      @(posedge clk);
      #1;
      pif.hpos_i = '0;
      pif.vpos_i = '0;
      @(posedge clk);
      #1;
      check({name, ".en"}, 32'(pif.enable_o), 32'(exp_en));
      check({name, ".rgb"}, 32'({pif.red_o, pif.green_o, pif.blue_o}), 32'(exp_rgb));
   endtask

   initial begin
      pif.frame_start_i = 1'b0;
      pif.tank_left_i   = '0;
      pif.level_i       = 4'd1;
      pif.lives_i       = 8'h23;
      pif.hpos_i        = '0;
      pif.vpos_i        = '0;
      pif.glyph_data_i  = '0;

      //             tanks  lives  x    y    glyph  addr    en    rgb
      vt[0]  = '{6'd20, 8'h23, 486, 40,  8'h00, 10'd0,   1'b1, 24'h808080};
      vt[1]  = '{6'd20, 8'h23, 502, 100, 8'h00, 10'd0,   1'b0, 24'h000000};
      vt[2]  = '{6'd21, 8'h23, 502, 100, 8'h00, 10'd0,   1'b1, 24'h808080};
      vt[3]  = '{6'd21, 8'h23, 502, 110, 8'h00, 10'd0,   1'b0, 24'h000000};
      vt[4]  = '{6'd21, 8'h23, 486, 280, 8'h00, 10'd0,   1'b1, 24'h808080};
      vt[5]  = '{6'd40, 8'h23, 502, 280, 8'h00, 10'd0,   1'b1, 24'h808080};
      vt[6]  = '{6'd40, 8'h23, 502, 292, 8'h00, 10'd0,   1'b0, 24'h000000};
      vt[7]  = '{6'd40, 8'h23, 518, 40,  8'h00, 10'd0,   1'b0, 24'h000000};
      vt[8]  = '{6'd0,  8'h23, 486, 40,  8'h00, 10'd0,   1'b0, 24'h000000};
      vt[9]  = '{6'd0,  8'h23, 501, 389, 8'h00, 10'd0,   1'b1, 24'hE0A000};
      vt[10] = '{6'd0,  8'h23, 517, 389, 8'h00, 10'd0,   1'b0, 24'h000000};
      vt[11] = '{6'd0,  8'h23, 485, 420, 8'h00, 10'd0,   1'b1, 24'hE0A000};
      vt[12] = '{6'd0,  8'h23, 501, 420, 8'h00, 10'd0,   1'b0, 24'h000000};
      vt[13] = '{6'd0,  8'h23, 464, 320, 8'h80, 10'd352, 1'b1, 24'h000000};
      vt[14] = '{6'd0,  8'h23, 466, 320, 8'h80, 10'd352, 1'b1, 24'hE0E0E0};
      vt[15] = '{6'd0,  8'h23, 560, 326, 8'h00, 10'd35,  1'b1, 24'hE0E0E0};
      vt[16] = '{6'd0,  8'h23, 575, 351, 8'h01, 10'd47,  1'b1, 24'h000000};
      vt[17] = '{6'd0,  8'h23, 576, 330, 8'h00, 10'd0,   1'b0, 24'h000000};
      vt[18] = '{6'd0,  8'h2F, 581, 389, 8'h00, 10'd0,   1'b1, 24'hE0A000};
      vt[19] = '{6'd0,  8'h2F, 597, 389, 8'h00, 10'd0,   1'b0, 24'h000000};

      repeat (3) @(posedge clk);
      #1;
      check("reset.en", 32'(pif.enable_o), 32'd0);
      check("reset.rgb", 32'({pif.red_o, pif.green_o, pif.blue_o}), 32'd0);
      check("reset.addr", 32'(pif.glyph_addr_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Before any frame_start_i nothing is drawn, not even the caption.
      probe("unprimed.cap", 464, 320, 8'h00, 10'd352, 1'b0, 24'h000000);

      // Table: each record latched by one frame, then probed.
      for (int i = 0; i < 20; i++) begin
         pif.tank_left_i = vt[i].tanks;
         pif.lives_i     = vt[i].lives;
         frame_pulse();
         probe($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].glyph,
               vt[i].addr, vt[i].en, vt[i].rgb);
      end

      // Mid-frame stat change is invisible until the next frame.
      pif.tank_left_i = 6'd20;
      frame_pulse();
      probe("midframe.before", 486, 40, 8'h00, 10'd0, 1'b1, 24'h808080);
      pif.tank_left_i = 6'd0;
      probe("midframe.held", 486, 40, 8'h00, 10'd0, 1'b1, 24'h808080);
      frame_pulse();
      probe("midframe.after", 486, 40, 8'h00, 10'd0, 1'b0, 24'h000000);

      // Level banner: 120 frames including the trigger frame.
      pif.level_i = 4'd2;
      frame_pulse();
      probe("banner.fg", 464, 320, 8'h80, 10'd352, 1'b1, 24'hFFD000);
      probe("banner.bg", 466, 320, 8'h80, 10'd352, 1'b1, 24'h000000);
      frames(119);
      probe("banner.last", 464, 320, 8'h80, 10'd352, 1'b1, 24'hFFD000);
      frame_pulse();
      probe("banner.end.fg", 464, 320, 8'h80, 10'd352, 1'b1, 24'h000000);
      probe("banner.end.bg", 466, 320, 8'h80, 10'd352, 1'b1, 24'hE0E0E0);

      // Change again at the 60th banner frame: 120 more frames from there.
      pif.level_i = 4'd3;
      frame_pulse();
      frames(59);
      pif.level_i = 4'd4;
      frame_pulse();
      frames(119);
      probe("reload.last", 464, 320, 8'h80, 10'd352, 1'b1, 24'hFFD000);
      frame_pulse();
      probe("reload.end", 464, 320, 8'h80, 10'd352, 1'b1, 24'h000000);

      // Level 12 saturates to digit char 10 (banner active again).
      pif.level_i = 4'd12;
      frame_pulse();
      probe("digit.sat", 560, 320, 8'h00, 10'd160, 1'b1, 24'h000000);

      // Life loss for player 0 (15 -> 3 first, let that settle, then 3 -> 2).
      pif.lives_i = 8'h23;
      frames(65);
      pif.lives_i = 8'h22;
      frame_pulse();
      probe("blink.load", 469, 389, 8'h00, 10'd0, 1'b1, 24'hE0A000);
      for (int k = 1; k <= 64; k++) begin
         int  cnt;
         logic hide;
         cnt  = 64 - k;
         hide = BLINK_ON && (cnt != 0) && ((cnt & 8) != 0);
         frame_pulse();
         probe($sformatf("blink.f%0d", k), 469, 389, 8'h00, 10'd0,
               !hide, hide ? 24'h000000 : 24'hE0A000);
      end

      // Asynchronous reset mid-frame while a tank pixel is on screen.
      pif.tank_left_i = 6'd20;
      frame_pulse();
      @(negedge clk);
      pif.hpos_i = 10'd483;
      pif.vpos_i = 10'd34;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("prereset.en", 32'(pif.enable_o), 32'd1);
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midreset.en", 32'(pif.enable_o), 32'd0);
      check("midreset.rgb", 32'({pif.red_o, pif.green_o, pif.blue_o}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("postreset.en", 32'(pif.enable_o), 32'd0);
      // First frame after reset primes only: level 12 vs cleared 0 is no banner.
      frame_pulse();
      probe("postreset.tank", 483, 34, 8'h00, 10'd0, 1'b1, 24'h808080);
      probe("postreset.cap", 464, 320, 8'h80, 10'd352, 1'b1, 24'h000000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
